// File: rtl/sp_pkg.sv
// Shared definitions for the spike beat serializer.
//   SP_COUNT_COPY / SP_W_DEF : default spike vector width (count copy + 11 tag bits)
//   nbeat()                  : number of BEAT_W beats needed to carry one vector
//   sp_state_e               : output FSM states
package sp_pkg;

    localparam int SP_COUNT_COPY = 32;
    localparam int SP_W_DEF      = SP_COUNT_COPY + 11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sp_state_e;

    // Ceiling division: beats per vector.
    function automatic int nbeat(input int sp_w, input int beat_w);
        return (sp_w + beat_w - 1) / beat_w;
    endfunction

endpackage

// File: rtl/sp_beat_serializer_if.sv
// Handshake bundle of the spike beat serializer.
//   i_sp_valid / i_sp_ready / i_sp                        : vector input from the encoder
//   o_beat_valid / o_beat_ready / o_beat_data / o_beat_last : narrow beat output to the link
// slave  : serializer view (consumes vectors, produces beats)
// master : environment view (produces vectors, consumes beats)
interface sp_beat_serializer_if #(
    parameter int SP_W   = sp_pkg::SP_W_DEF,
    parameter int BEAT_W = 8
);
    logic              i_sp_valid;
    logic              i_sp_ready;
    logic [SP_W-1:0]   i_sp;
    logic              o_beat_valid;
    logic              o_beat_ready;
    logic [BEAT_W-1:0] o_beat_data;
    logic              o_beat_last;

    modport slave (
        input  i_sp_valid, i_sp, o_beat_ready,
        output i_sp_ready, o_beat_valid, o_beat_data, o_beat_last
    );

    modport master (
        output i_sp_valid, i_sp, o_beat_ready,
        input  i_sp_ready, o_beat_valid, o_beat_data, o_beat_last
    );
endinterface

// File: rtl/sp_fifo.sv
// Synchronous FIFO with registered read/write pointers.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   i_push, i_data : write request and data (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_head         : entry at the read pointer
//   o_full, o_empty, o_level : occupancy, all decoded from the registered pointers
module sp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/sp_beat_serializer.sv
// Spike beat serializer: buffers wide spike vectors and emits them as
// BEAT_W-wide beats, LSB first, optionally dropping (and counting) zero vectors.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : vector input handshake and beat output handshake
//   fifo_level  : occupied FIFO entries
//   zero_cnt    : suppressed zero vectors, saturating at 16'hFFFF
module sp_beat_serializer
    import sp_pkg::*;
#(
    parameter int SP_W      = SP_W_DEF,
    parameter int BEAT_W    = 8,
    parameter int DEPTH     = 4,
    parameter int ZERO_SKIP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sp_beat_serializer_if.slave    bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            zero_cnt
);
    localparam int NBEAT = nbeat(SP_W, BEAT_W);
    localparam int SHW   = NBEAT * BEAT_W;
    localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam bit SKIP  = (ZERO_SKIP != 0);

    sp_state_e       r_state;
    sp_state_e       w_state_nxt;
    logic [SHW-1:0]  r_shift;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_zero_cnt;

    logic            w_full;
    logic            w_empty;
    logic [SP_W-1:0] w_head;
    logic            w_accept;
    logic            w_is_zero;
    logic            w_push;
    logic            w_zero_hit;
    logic            w_pop;
    logic            w_load;
    logic            w_shift;
    logic            w_last;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ready never looks at a same-cycle pop: a full FIFO stays closed for that cycle.
    assign bus.i_sp_ready = !w_full;
    assign w_accept       = bus.i_sp_valid && !w_full;
    assign w_is_zero      = (bus.i_sp == '0);
    assign w_zero_hit     = w_accept && SKIP && w_is_zero;
    assign w_push         = w_accept && !(SKIP && w_is_zero);

    sp_fifo #(
        .W     (SP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (bus.i_sp),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_last           = (r_cnt == CW'(NBEAT - 1));
    assign bus.o_beat_valid = (r_state == SEND);
    assign bus.o_beat_last  = (r_state == SEND) && w_last;
    assign bus.o_beat_data  = r_shift[BEAT_W-1:0];
    assign zero_cnt         = r_zero_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.o_beat_ready) begin
                    if (!w_last) begin
                        w_shift = 1'b1;
                    end else if (!w_empty) begin
                        // Chain straight into the next vector without an idle cycle.
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift register is zero-extended on load so the padding bits of the last beat are 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= SHW'(w_head);
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shift <= r_shift >> BEAT_W;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_zero_cnt <= '0;
        else if (w_zero_hit) r_zero_cnt <= sat_inc16(r_zero_cnt);
    end

endmodule

// File: tb/tb_sp_beat_serializer.sv
module tb_sp_beat_serializer;
    localparam int SPW = 43;
    localparam int BW  = 8;
    localparam int DEP = 4;
    localparam int NB  = (SPW + BW - 1) / BW;
    localparam int LW  = $clog2(DEP) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_beat_serializer_if #(.SP_W(SPW), .BEAT_W(BW)) bus_a ();
    sp_beat_serializer_if #(.SP_W(SPW), .BEAT_W(BW)) bus_b ();

    logic [LW-1:0] lvl_a, lvl_b;
    logic [15:0]   zc_a, zc_b;

    sp_beat_serializer #(.SP_W(SPW), .BEAT_W(BW), .DEPTH(DEP), .ZERO_SKIP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .fifo_level(lvl_a), .zero_cnt(zc_a));
    sp_beat_serializer #(.SP_W(SPW), .BEAT_W(BW), .DEPTH(DEP), .ZERO_SKIP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .fifo_level(lvl_b), .zero_cnt(zc_b));

    int nchk = 0;
    int nerr = 0;

    // Expected beat stream per DUT: {last, data}
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];

    // Observations of the cycle just completed
    bit         acc_a, hs_a, acc_b, hs_b;
    logic [7:0] d_a, d_b;
    logic       l_a, l_b;

    function automatic logic [42:0] rand_vec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        if (t[42:0] == 43'd0) t[0] = 1'b1;
        return t[42:0];
    endfunction

    // Reference: a vector becomes NB beats of BW bits, LSB first; zero vectors vanish when skipped.
    function automatic void push_model(input logic [42:0] vec, input bit to_b);
        logic [63:0] w;
        logic [8:0]  b;
        if (!to_b && vec == 43'd0) return;
        for (int k = 0; k < NB; k++) begin
            w = 64'(vec) >> (k * BW);
            b = {(k == NB - 1), w[7:0]};
            if (to_b) exp_b.push_back(b);
            else      exp_a.push_back(b);
        end
    endfunction

    // Called at a falling edge after driving; records what the next rising edge does.
    task automatic step();
        acc_a = bus_a.i_sp_valid && bus_a.i_sp_ready;
        hs_a  = bus_a.o_beat_valid && bus_a.o_beat_ready;
        d_a   = bus_a.o_beat_data;
        l_a   = bus_a.o_beat_last;
        acc_b = bus_b.i_sp_valid && bus_b.i_sp_ready;
        hs_b  = bus_b.o_beat_valid && bus_b.o_beat_ready;
        d_b   = bus_b.o_beat_data;
        l_b   = bus_b.o_beat_last;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus_a.i_sp_valid = 1'b0; bus_a.i_sp = '0; bus_a.o_beat_ready = 1'b1;
        bus_b.i_sp_valid = 1'b0; bus_b.i_sp = '0; bus_b.o_beat_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.i_sp_valid = 1'b1;
        bus_a.i_sp = 43'h123;
        repeat (2) @(negedge clk);
        nchk++; if (bus_a.o_beat_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", bus_a.o_beat_valid); end
        nchk++; if (bus_a.o_beat_data !== 8'h00) begin nerr++; $display("FAIL rst_data got %h want 00", bus_a.o_beat_data); end
        nchk++; if (bus_a.o_beat_last !== 1'b0) begin nerr++; $display("FAIL rst_last got %b want 0", bus_a.o_beat_last); end
        nchk++; if (lvl_a !== 3'd0) begin nerr++; $display("FAIL rst_level got %0d want 0", lvl_a); end
        nchk++; if (zc_a !== 16'd0) begin nerr++; $display("FAIL rst_zero_cnt got %0d want 0", zc_a); end
        nchk++; if (bus_a.i_sp_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got %b want 1", bus_a.i_sp_ready); end
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        nchk++; if (lvl_a !== 3'd0) begin nerr++; $display("FAIL rst_no_accept level got %0d want 0", lvl_a); end
    endtask

    task automatic test_single();
        logic [7:0] eb [6];
        bit         ev;
        eb = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h05};
        bus_a.o_beat_ready = 1'b1;
        bus_a.i_sp_valid = 1'b1;
        bus_a.i_sp = 43'h5A5A5A5A5A5;
        step();
        nchk++; if (acc_a !== 1'b1) begin nerr++; $display("FAIL single_accept got %b want 1", acc_a); end
        bus_a.i_sp_valid = 1'b0;
        bus_a.i_sp = '0;
        for (int c = 1; c <= 8; c++) begin
            ev = (c >= 2 && c <= 7);
            nchk++; if (bus_a.o_beat_valid !== ev) begin nerr++; $display("FAIL single_valid cycle t+%0d got %b want %b", c, bus_a.o_beat_valid, ev); end
            if (ev) begin
                nchk++; if (bus_a.o_beat_data !== eb[c-2]) begin nerr++; $display("FAIL single_data beat %0d got %h want %h", c - 2, bus_a.o_beat_data, eb[c-2]); end
                nchk++; if (bus_a.o_beat_last !== (c == 7)) begin nerr++; $display("FAIL single_last beat %0d got %b want %b", c - 2, bus_a.o_beat_last, (c == 7)); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [42:0] v;
        logic [8:0]  held, e;
        int          got, stall;
        v = rand_vec();
        push_model(v, 1'b0);
        bus_a.o_beat_ready = 1'b1;
        bus_a.i_sp_valid = 1'b1;
        bus_a.i_sp = v;
        step();
        nchk++; if (acc_a !== 1'b1) begin nerr++; $display("FAIL bp_accept got %b want 1", acc_a); end
        bus_a.i_sp_valid = 1'b0;
        got = 0; stall = 0; held = '0;
        for (int c = 0; c < 20; c++) begin
            if (got == 2 && stall > 0) begin
                nchk++;
                if (bus_a.o_beat_valid !== 1'b1 || {bus_a.o_beat_last, bus_a.o_beat_data} !== held) begin
                    nerr++; $display("FAIL bp_hold got v=%b %h want v=1 %h", bus_a.o_beat_valid, {bus_a.o_beat_last, bus_a.o_beat_data}, held);
                end
            end
            if (bus_a.o_beat_valid && got == 2 && stall < 3) begin
                if (stall == 0) held = {bus_a.o_beat_last, bus_a.o_beat_data};
                bus_a.o_beat_ready = 1'b0;
                stall++;
            end else begin
                bus_a.o_beat_ready = 1'b1;
            end
            step();
            if (hs_a) begin
                got++;
                nchk++;
                if (exp_a.size() == 0) begin nerr++; $display("FAIL bp_beat got %h want none", {l_a, d_a}); end
                else begin e = exp_a.pop_front(); if ({l_a, d_a} !== e) begin nerr++; $display("FAIL bp_beat got %h want %h", {l_a, d_a}, e); end end
            end
        end
        bus_a.o_beat_ready = 1'b1;
        nchk++; if (got !== NB) begin nerr++; $display("FAIL bp_count got %0d want %0d", got, NB); end
        nchk++; if (stall !== 3) begin nerr++; $display("FAIL bp_stall got %0d want 3", stall); end
    endtask

    task automatic test_fill();
        logic [42:0] v;
        logic [8:0]  e;
        int          nacc, got, gaps;
        bus_a.o_beat_ready = 1'b0;
        nacc = 0;
        v = rand_vec();
        bus_a.i_sp_valid = 1'b1;
        bus_a.i_sp = v;
        for (int c = 0; c < 20 && nacc < 5; c++) begin
            step();
            if (acc_a) begin
                push_model(v, 1'b0);
                nacc++;
                v = rand_vec();
                bus_a.i_sp = v;
            end
        end
        nchk++; if (nacc !== 5) begin nerr++; $display("FAIL fill_accepts got %0d want 5", nacc); end
        nchk++; if (lvl_a !== 3'd4) begin nerr++; $display("FAIL fill_level got %0d want 4", lvl_a); end
        for (int c = 0; c < 3; c++) begin
            nchk++; if (bus_a.i_sp_ready !== 1'b0) begin nerr++; $display("FAIL fill_ready got %b want 0", bus_a.i_sp_ready); end
            step();
            nchk++; if (acc_a !== 1'b0) begin nerr++; $display("FAIL fill_wait got %b want 0", acc_a); end
        end
        bus_a.o_beat_ready = 1'b1;
        got = 0; gaps = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (acc_a) begin
                push_model(v, 1'b0);
                bus_a.i_sp_valid = 1'b0;
            end
            if (hs_a) begin
                got++;
                nchk++;
                if (exp_a.size() == 0) begin nerr++; $display("FAIL fill_beat got %h want none", {l_a, d_a}); end
                else begin e = exp_a.pop_front(); if ({l_a, d_a} !== e) begin nerr++; $display("FAIL fill_beat %0d got %h want %h", got, {l_a, d_a}, e); end end
            end else if (got > 0 && got < 6 * NB) begin
                gaps++;
            end
        end
        bus_a.i_sp_valid = 1'b0;
        nchk++; if (got !== 6 * NB) begin nerr++; $display("FAIL fill_count got %0d want %0d", got, 6 * NB); end
        nchk++; if (gaps !== 0) begin nerr++; $display("FAIL fill_gaps got %0d want 0", gaps); end
        nchk++; if (exp_a.size() !== 0) begin nerr++; $display("FAIL fill_left got %0d want 0", exp_a.size()); end
    endtask

    task automatic test_zero();
        logic [42:0] vals [3];
        logic [8:0]  e;
        int          ga, gb;
        vals = '{43'd0, 43'd1, 43'd0};
        do_reset();
        ga = 0; gb = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 3) begin
                bus_a.i_sp_valid = 1'b1; bus_a.i_sp = vals[c];
                bus_b.i_sp_valid = 1'b1; bus_b.i_sp = vals[c];
            end else begin
                bus_a.i_sp_valid = 1'b0; bus_b.i_sp_valid = 1'b0;
            end
            step();
            if (c < 3) begin
                nchk++; if (acc_a !== 1'b1 || acc_b !== 1'b1) begin nerr++; $display("FAIL zero_accept got %b%b want 11", acc_a, acc_b); end
                push_model(vals[c], 1'b0);
                push_model(vals[c], 1'b1);
            end
            if (hs_a) begin
                ga++;
                nchk++;
                if (exp_a.size() == 0) begin nerr++; $display("FAIL zero_beat_a got %h want none", {l_a, d_a}); end
                else begin e = exp_a.pop_front(); if ({l_a, d_a} !== e) begin nerr++; $display("FAIL zero_beat_a got %h want %h", {l_a, d_a}, e); end end
            end
            if (hs_b) begin
                gb++;
                nchk++;
                if (exp_b.size() == 0) begin nerr++; $display("FAIL zero_beat_b got %h want none", {l_b, d_b}); end
                else begin e = exp_b.pop_front(); if ({l_b, d_b} !== e) begin nerr++; $display("FAIL zero_beat_b got %h want %h", {l_b, d_b}, e); end end
            end
        end
        nchk++; if (ga !== NB) begin nerr++; $display("FAIL zero_count_a got %0d want %0d", ga, NB); end
        nchk++; if (gb !== 3 * NB) begin nerr++; $display("FAIL zero_count_b got %0d want %0d", gb, 3 * NB); end
        nchk++; if (zc_a !== 16'd2) begin nerr++; $display("FAIL zero_cnt_a got %0d want 2", zc_a); end
        nchk++; if (zc_b !== 16'd0) begin nerr++; $display("FAIL zero_cnt_b got %0d want 0", zc_b); end
        nchk++; if (lvl_b !== 3'd0) begin nerr++; $display("FAIL zero_level_b got %0d want 0", lvl_b); end
    endtask

    task automatic test_simul();
        logic [42:0] v;
        logic [8:0]  e;
        int          got;
        bit          pushed, just;
        do_reset();
        bus_a.o_beat_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = rand_vec();
            bus_a.i_sp_valid = 1'b1; bus_a.i_sp = v;
            step();
            nchk++; if (acc_a !== 1'b1) begin nerr++; $display("FAIL simul_fill_accept got %b want 1", acc_a); end
            push_model(v, 1'b0);
        end
        bus_a.i_sp_valid = 1'b0;
        step(); step();
        nchk++; if (lvl_a !== 3'd2) begin nerr++; $display("FAIL simul_level_pre got %0d want 2", lvl_a); end
        bus_a.o_beat_ready = 1'b1;
        got = 0; pushed = 1'b0; just = 1'b0;
        v = rand_vec();
        for (int c = 0; c < 40; c++) begin
            if (just) begin
                nchk++; if (lvl_a !== 3'd2) begin nerr++; $display("FAIL simul_level_post got %0d want 2", lvl_a); end
                just = 1'b0;
            end
            if (!pushed && bus_a.o_beat_valid && bus_a.o_beat_last) begin
                nchk++; if (lvl_a !== 3'd2) begin nerr++; $display("FAIL simul_level_at got %0d want 2", lvl_a); end
                bus_a.i_sp_valid = 1'b1; bus_a.i_sp = v;
                pushed = 1'b1; just = 1'b1;
            end else begin
                bus_a.i_sp_valid = 1'b0;
            end
            step();
            if (just) begin
                nchk++; if (acc_a !== 1'b1) begin nerr++; $display("FAIL simul_accept got %b want 1", acc_a); end
                push_model(v, 1'b0);
            end
            if (hs_a) begin
                got++;
                nchk++;
                if (exp_a.size() == 0) begin nerr++; $display("FAIL simul_beat got %h want none", {l_a, d_a}); end
                else begin e = exp_a.pop_front(); if ({l_a, d_a} !== e) begin nerr++; $display("FAIL simul_beat got %h want %h", {l_a, d_a}, e); end end
            end
        end
        nchk++; if (got !== 4 * NB) begin nerr++; $display("FAIL simul_count got %0d want %0d", got, 4 * NB); end
    endtask

    task automatic test_reset_mid();
        logic [42:0] v;
        logic [8:0]  e;
        int          got, c;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            v = rand_vec();
            bus_a.i_sp_valid = 1'b1; bus_a.i_sp = v;
            step();
            push_model(v, 1'b0);
        end
        bus_a.i_sp_valid = 1'b0;
        got = 0; c = 0;
        while (c < 20 && !(bus_a.o_beat_valid && got == 3)) begin
            step();
            if (hs_a) begin
                got++;
                nchk++;
                if (exp_a.size() == 0) begin nerr++; $display("FAIL rmid_beat got %h want none", {l_a, d_a}); end
                else begin e = exp_a.pop_front(); if ({l_a, d_a} !== e) begin nerr++; $display("FAIL rmid_beat got %h want %h", {l_a, d_a}, e); end end
            end
            c++;
        end
        nchk++; if (got !== 3) begin nerr++; $display("FAIL rmid_reach got %0d want 3", got); end
        rst_n = 1'b0;
        #1;
        nchk++; if (bus_a.o_beat_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid got %b want 0", bus_a.o_beat_valid); end
        nchk++; if (lvl_a !== 3'd0) begin nerr++; $display("FAIL rmid_level got %0d want 0", lvl_a); end
        nchk++; if (bus_a.i_sp_ready !== 1'b1) begin nerr++; $display("FAIL rmid_ready got %b want 1", bus_a.i_sp_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_a.delete();
        v = rand_vec();
        bus_a.i_sp_valid = 1'b1; bus_a.i_sp = v;
        step();
        push_model(v, 1'b0);
        bus_a.i_sp_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (hs_a) begin
                got++;
                nchk++;
                if (exp_a.size() == 0) begin nerr++; $display("FAIL rmid_after got %h want none", {l_a, d_a}); end
                else begin e = exp_a.pop_front(); if ({l_a, d_a} !== e) begin nerr++; $display("FAIL rmid_after beat %0d got %h want %h", got - 1, {l_a, d_a}, e); end end
            end
        end
        nchk++; if (got !== NB) begin nerr++; $display("FAIL rmid_after_count got %0d want %0d", got, NB); end
    endtask

    task automatic test_sat();
        bit saw;
        do_reset();
        saw = 1'b0;
        bus_a.i_sp_valid = 1'b1;
        bus_a.i_sp = '0;
        for (int i = 0; i < 1000; i++) begin step(); if (hs_a) saw = 1'b1; end
        nchk++; if (zc_a !== 16'd1000) begin nerr++; $display("FAIL sat_mid got %0d want 1000", zc_a); end
        for (int i = 1000; i < 65535; i++) begin step(); if (hs_a) saw = 1'b1; end
        nchk++; if (zc_a !== 16'hFFFF) begin nerr++; $display("FAIL sat_full got %h want ffff", zc_a); end
        step();
        nchk++; if (acc_a !== 1'b1) begin nerr++; $display("FAIL sat_accept got %b want 1", acc_a); end
        nchk++; if (zc_a !== 16'hFFFF) begin nerr++; $display("FAIL sat_hold got %h want ffff", zc_a); end
        nchk++; if (saw !== 1'b0) begin nerr++; $display("FAIL sat_no_beats got %b want 0", saw); end
        nchk++; if (lvl_a !== 3'd0) begin nerr++; $display("FAIL sat_level got %0d want 0", lvl_a); end
        bus_a.i_sp_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_fill();
        test_zero();
        test_simul();
        test_reset_mid();
        test_sat();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
